// File: rtl/ws2812_led_driver.sv
// WS2812 one-wire LED driver.
// Serialises NUM_LEDS 24-bit {R,G,B} colours onto LED_DOUT in GRB order, MSB
// first, and closes each frame with a TRESET_CYC-long low latch gap.
module ws2812_led_driver #(
    parameter int NUM_LEDS   = 1,
    parameter int T0H_CYC    = 20,
    parameter int T1H_CYC    = 40,
    parameter int TBIT_CYC   = 62,
    parameter int TRESET_CYC = 3000,
    localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          CLK,
    input  logic          RESET_n,
    input  logic          START,
    input  logic [23:0]   COLOR,
    output logic [IW-1:0] LED_INDEX,
    output logic          BUSY,
    output logic          FRAME_DONE,
    output logic          LED_DOUT
);

    // One shared cycle counter serves both bit timing and the latch gap.
    localparam int CMAX = (TBIT_CYC > TRESET_CYC) ? TBIT_CYC : TRESET_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] TRST_LAST = CW'(TRESET_CYC - 1);
    localparam logic [CW-1:0] T0H       = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H       = CW'(T1H_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BIT,
        LATCH
    } state_t;

    state_t        state;
    logic [23:0]   shift_reg;
    logic [4:0]    bit_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] cyc_nxt;

    function automatic logic [CW-1:0] high_time(input logic b);
        return b ? T1H : T0H;
    endfunction

    // Next value of the cycle counter, shared by BIT and LATCH.
    always_comb begin
        cyc_nxt = cyc_cnt + 1'b1;
    end

    // Frame sequencer; LED_DOUT is computed for the upcoming cycle so it stays registered.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            LED_INDEX  <= '0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
            LED_DOUT   <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    LED_DOUT <= 1'b0;
                    if (START) begin
                        state     <= LOAD;
                        BUSY      <= 1'b1;
                        LED_INDEX <= '0;
                    end
                end
                LOAD: begin
                    shift_reg <= {COLOR[15:8], COLOR[23:16], COLOR[7:0]};
                    bit_cnt   <= 5'd23;
                    cyc_cnt   <= '0;
                    state     <= BIT;
                    // First bit goes high on the same edge that enters BIT.
                    LED_DOUT  <= (high_time(COLOR[15]) != '0);
                end
                BIT: begin
                    if (cyc_cnt == TBIT_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 5'd0) begin
                            LED_DOUT <= 1'b0;
                            if (LED_INDEX != IDX_LAST) begin
                                LED_INDEX <= LED_INDEX + 1'b1;
                                state     <= LOAD;
                            end else begin
                                state <= LATCH;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt - 5'd1;
                            shift_reg <= {shift_reg[22:0], 1'b0};
                            LED_DOUT  <= (high_time(shift_reg[22]) != '0);
                        end
                    end else begin
                        cyc_cnt  <= cyc_nxt;
                        LED_DOUT <= (cyc_nxt < high_time(shift_reg[23]));
                    end
                end
                LATCH: begin
                    LED_DOUT <= 1'b0;
                    if (cyc_cnt == TRST_LAST) begin
                        cyc_cnt    <= '0;
                        state      <= IDLE;
                        BUSY       <= 1'b0;
                        FRAME_DONE <= 1'b1;
                        LED_INDEX  <= '0;
                    end else begin
                        cyc_cnt <= cyc_nxt;
                    end
                end
                default: begin
                    state    <= IDLE;
                    BUSY     <= 1'b0;
                    LED_DOUT <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_led_driver.sv
// Scoreboard bench for ws2812_led_driver with four pixels and default timing.
// Stimulus pushes expected per-frame GRB words; a negedge monitor decodes the
// serial line and compares against them.
module tb_ws2812_led_driver;

    localparam int NL        = 4;
    localparam int TB        = 62;
    localparam int T0        = 20;
    localparam int T1        = 40;
    localparam int TR        = 3000;
    localparam int FRAME_LEN = NL * (1 + 24 * TB) + TR;

    logic        CLK = 1'b0;
    logic        RESET_n;
    logic        START;
    logic [23:0] COLOR;
    logic [1:0]  LED_INDEX;
    logic        BUSY;
    logic        FRAME_DONE;
    logic        LED_DOUT;

    logic [23:0] color_tab [NL];

    typedef struct {
        logic [24*NL-1:0] grb;
        bit               chk_gap;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int frames_done = 0;

    ws2812_led_driver #(
        .NUM_LEDS  (NL),
        .T0H_CYC   (T0),
        .T1H_CYC   (T1),
        .TBIT_CYC  (TB),
        .TRESET_CYC(TR)
    ) dut (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .START     (START),
        .COLOR     (COLOR),
        .LED_INDEX (LED_INDEX),
        .BUSY      (BUSY),
        .FRAME_DONE(FRAME_DONE),
        .LED_DOUT  (LED_DOUT)
    );

    always #10 CLK = ~CLK;

    // Upstream colour stage: colour looked up by the pixel index the driver presents.
    assign COLOR = color_tab[LED_INDEX];

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input bit gap);
        exp_t e;
        e.grb = '0;
        for (int i = 0; i < NL; i++) begin
            logic [23:0] c;
            c = color_tab[i];
            e.grb[i*24 +: 24] = {c[15:8], c[23:16], c[7:0]};
        end
        e.chk_gap = gap;
        q.push_back(e);
    endtask

    task automatic rand_tab();
        for (int i = 0; i < NL; i++) color_tab[i] = 24'($urandom);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME_LEN + 200 && !seen; i++) begin
            @(negedge CLK);
            seen = FRAME_DONE;
        end
        chk(seen, "frame_done_timeout", seen, 1);
    endtask

    task automatic wait_index(input int v);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME_LEN && !seen; i++) begin
            @(negedge CLK);
            seen = BUSY && (int'(LED_INDEX) == v);
        end
        chk(seen, "wait_index_timeout", seen, 1);
    endtask

    // Monitor: decode LED_DOUT, time frames, compare with the scoreboard queue.
    initial begin
        exp_t cur;
        bit   in_frame = 0, prev_busy = 0, prev_dout = 0, prev_fd = 0, have_rise = 0;
        int   t = 0, idle_len = 0, pix = 0, nbits = 0, hc = 0, last_rise = 0;
        logic [23:0] word = '0;
        forever begin
            @(negedge CLK);
            if (!RESET_n) begin
                in_frame = 0; prev_busy = 0; prev_dout = 0; prev_fd = 0; idle_len = 0;
            end else begin
                chk(!(LED_DOUT && !BUSY), "dout_high_outside_busy", LED_DOUT, 0);
                chk(!(FRAME_DONE && prev_fd), "frame_done_width", 2, 1);
                if (BUSY && !prev_busy) begin
                    chk(q.size() > 0, "unexpected_frame", 0, 1);
                    in_frame = (q.size() > 0);
                    if (in_frame) begin
                        cur = q.pop_front();
                        if (cur.chk_gap) chk(idle_len == 1, "idle_gap", idle_len, 1);
                    end
                    t = 0; pix = 0; nbits = 0; word = '0; hc = 0; have_rise = 0;
                end else if (in_frame) begin
                    t++;
                end
                idle_len = BUSY ? 0 : idle_len + 1;
                if (FRAME_DONE && !prev_fd)
                    chk(in_frame, "frame_done_outside_frame", in_frame, 1);
                if (in_frame) begin
                    if (LED_DOUT && !prev_dout) begin
                        chk(int'(LED_INDEX) == pix, "led_index", LED_INDEX, pix);
                        if (!have_rise) chk(t == 1, "first_rise_latency", t, 1);
                        else chk(t - last_rise == ((nbits == 0) ? TB + 1 : TB),
                                 "bit_period", t - last_rise, (nbits == 0) ? TB + 1 : TB);
                        have_rise = 1; last_rise = t; hc = 0;
                    end
                    if (LED_DOUT) hc++;
                    if (!LED_DOUT && prev_dout && pix < NL) begin
                        int exp_h;
                        exp_h = cur.grb[pix*24 + 23 - nbits] ? T1 : T0;
                        chk(hc == exp_h, "high_time", hc, exp_h);
                        word = {word[22:0], (hc == T1)};
                        nbits++;
                        if (nbits == 24) begin
                            chk(word == cur.grb[pix*24 +: 24], "pixel_grb", word, cur.grb[pix*24 +: 24]);
                            pix++; nbits = 0; word = '0;
                        end
                    end
                    if (FRAME_DONE && !prev_fd) begin
                        chk(t == FRAME_LEN, "frame_length", t, FRAME_LEN);
                        chk(pix == NL, "pixels_sent", pix, NL);
                        chk(LED_INDEX == 2'd0, "index_after_frame", LED_INDEX, 0);
                        chk(!BUSY, "busy_after_frame", BUSY, 0);
                        frames_done++;
                        in_frame = 0;
                    end
                end
                prev_busy = BUSY; prev_dout = LED_DOUT; prev_fd = FRAME_DONE;
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int rises;
        bit prev;
        RESET_n = 1'b0;
        START   = 1'b0;
        for (int i = 0; i < NL; i++) color_tab[i] = '0;
        repeat (3) @(negedge CLK);
        chk(BUSY == 1'b0, "reset_busy", BUSY, 0);
        chk(LED_DOUT == 1'b0, "reset_dout", LED_DOUT, 0);
        chk(FRAME_DONE == 1'b0, "reset_frame_done", FRAME_DONE, 0);
        chk(LED_INDEX == 2'd0, "reset_index", LED_INDEX, 0);
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Fixed per-pixel colours.
        color_tab[0] = 24'h000020; color_tab[1] = 24'h001400;
        color_tab[2] = 24'h140000; color_tab[3] = 24'h090909;
        push_frame(0); pulse_start(); wait_done();

        // All-ones / all-zeros pixels.
        color_tab[0] = 24'hFFFFFF; color_tab[1] = 24'h000000;
        color_tab[2] = 24'hFFFFFF; color_tab[3] = 24'h000000;
        push_frame(0); pulse_start(); wait_done();

        // Mid-pixel colour change and mid-frame START are both ignored.
        rand_tab(); push_frame(0); pulse_start();
        wait_index(1);
        repeat (300) @(negedge CLK);
        color_tab[1] = ~color_tab[1];
        pulse_start();
        wait_done();
        repeat (20) @(negedge CLK);
        chk(!BUSY, "start_while_busy_ignored", BUSY, 0);

        // START held high: two back-to-back frames with a single idle cycle.
        rand_tab(); push_frame(0); push_frame(1);
        START = 1'b1;
        wait_done();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 5 && !seen; i++) begin
                @(negedge CLK);
                seen = BUSY;
            end
            chk(seen, "restart_timeout", seen, 1);
        end
        START = 1'b0;
        wait_done();

        // Reset during pixel 2, bit 5, while the line is high.
        rand_tab(); push_frame(0); pulse_start();
        wait_index(2);
        rises = 0; prev = LED_DOUT;
        for (int i = 0; i < 2000 && rises < 6; i++) begin
            @(negedge CLK);
            if (LED_DOUT && !prev) rises++;
            prev = LED_DOUT;
        end
        chk(rises == 6 && LED_DOUT, "reach_pixel2_bit5", rises, 6);
        #2 RESET_n = 1'b0;
        #1;
        chk(LED_DOUT == 1'b0, "async_reset_dout", LED_DOUT, 0);
        chk(BUSY == 1'b0, "async_reset_busy", BUSY, 0);
        chk(LED_INDEX == 2'd0, "async_reset_index", LED_INDEX, 0);
        repeat (3) @(negedge CLK);
        RESET_n = 1'b1;
        repeat (10) @(negedge CLK);
        chk(!BUSY && !FRAME_DONE, "idle_after_reset", BUSY, 0);

        // Fresh frame after reset restarts at pixel 0.
        rand_tab(); push_frame(0); pulse_start(); wait_done();

        repeat (5) @(negedge CLK);
        chk(q.size() == 0, "scoreboard_empty", q.size(), 0);
        chk(frames_done == 6, "frames_completed", frames_done, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
